// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap/CSR block: CSR addresses,
// the CSR access opcode, exception/interrupt cause codes and the
// read-modify-write helper used by CSR instructions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Synchronous exception causes (mcause[31]=0)
  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  // External interrupt line k reports cause IRQ_EXT_BASE + k (mcause[31]=1)
  localparam logic [4:0] IRQ_EXT_BASE = 5'd16;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // New CSR value for a write/set/clear access before WARL masking
  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old, logic [31:0] wdata);
    case (op)
      CSR_OP_WRITE: csr_apply = wdata;
      CSR_OP_SET:   csr_apply = old | wdata;
      CSR_OP_CLEAR: csr_apply = old & ~wdata;
      default:      csr_apply = old;
    endcase
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for level interrupt lines arriving asynchronously
// to clk. Output follows input exactly two rising edges later.
module irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture; both stages clear on reset so no stale level survives
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trap_csr.sv
// Machine-mode trap unit and CSR file: exceptions, external interrupts,
// mret, CSR read/write/set/clear with WARL fields, same-cycle redirect.
// Optional 64-bit mcycle/minstret counters when PEARL_COUNTERS_EN is defined.
module trap_csr
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ   = 4,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100,
  parameter logic [31:0] HARTID    = 32'd0
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               ex_valid_i,
  input  logic [31:0]        ex_pc_i,
  input  logic               trap_i,
  input  logic [3:0]         trap_cause_i,
  input  logic [31:0]        trap_tval_i,
  input  logic               mret_i,
  input  logic               retire_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [1:0]         csr_op_i,
  input  logic [31:0]        csr_wdata_i,
  output logic [31:0]        csr_rdata_o,
  output logic               csr_illegal_o,
  output logic               redirect_o,
  output logic [31:0]        redirect_pc_o,
  output logic               irq_take_o
);

  logic [NUM_IRQ-1:0] mip, mie_q, pend;
  logic               mstatus_mie, mstatus_mpie;
  logic [31:0]        mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  csr_op_e            op;
  logic               known, read_only, csr_we, irq_take;
  logic [31:0]        rdata, wval, tvec_base;
  logic [4:0]         irq_idx, irq_cause;

  irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk  (clk),
    .arst (arst),
    .d    (irq_i),
    .q    (mip)
  );

`ifdef PEARL_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  assign op   = csr_op_e'(csr_op_i);
  assign pend = mip & mie_q;

  // Lowest pending-and-enabled line wins
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[i]) irq_idx = 5'(i);
  end

  assign irq_cause = IRQ_EXT_BASE + irq_idx;
  assign irq_take  = mstatus_mie & (|pend) & ex_valid_i & ~trap_i & ~mret_i;
  assign tvec_base = {mtvec_q[31:2], 2'b00};

  // CSR read mux and address decode
  always_comb begin
    rdata     = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE_BIT]  = mstatus_mie;
        rdata[MSTATUS_MPIE_BIT] = mstatus_mpie;
      end
      CSR_MIE:      rdata[16 +: NUM_IRQ] = mie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MTVAL:    rdata = mtval_q;
      CSR_MIP: begin
        rdata[16 +: NUM_IRQ] = mip;
        read_only            = 1'b1;
      end
      CSR_MHARTID: begin
        rdata     = HARTID;
        read_only = 1'b1;
      end
`ifdef PEARL_COUNTERS_EN
      CSR_MCYCLE:    rdata = mcycle_q[31:0];
      CSR_MCYCLEH:   rdata = mcycle_q[63:32];
      CSR_MINSTRET:  rdata = minstret_q[31:0];
      CSR_MINSTRETH: rdata = minstret_q[63:32];
`endif
      default: known = 1'b0;
    endcase
  end

  assign csr_rdata_o   = rdata;
  assign csr_illegal_o = ~known | (read_only & (op != CSR_OP_NONE));
  assign wval          = csr_apply(op, rdata, csr_wdata_i);
  // Any trap-side event in the same cycle swallows the CSR write
  assign csr_we        = (op != CSR_OP_NONE) & ~csr_illegal_o & ~trap_i & ~mret_i & ~irq_take;
  assign irq_take_o    = irq_take;

  // Same-cycle redirect target
  always_comb begin
    redirect_o    = trap_i | mret_i | irq_take;
    redirect_pc_o = '0;
    if (trap_i)
      redirect_pc_o = tvec_base;
    else if (mret_i)
      redirect_pc_o = mepc_q;
    else if (irq_take)
      redirect_pc_o = mtvec_q[0] ? tvec_base + {25'd0, irq_cause, 2'b00} : tvec_base;
  end

  // Architectural trap state, in priority order trap > mret > irq > CSR write
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RST;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else if (trap_i) begin
      mepc_q       <= ex_pc_i;
      mcause_q     <= {28'd0, trap_cause_i};
      mtval_q      <= trap_tval_i;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (irq_take) begin
      mepc_q       <= ex_pc_i;
      mcause_q     <= {1'b1, 26'd0, irq_cause};
      mtval_q      <= '0;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (csr_we) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_mie  <= wval[MSTATUS_MIE_BIT];
          mstatus_mpie <= wval[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_q      <= wval[16 +: NUM_IRQ];
        CSR_MTVEC:    mtvec_q    <= wval & ~32'h2;
        CSR_MSCRATCH: mscratch_q <= wval;
        CSR_MEPC:     mepc_q     <= wval & ~32'h3;
        CSR_MCAUSE:   mcause_q   <= wval & 32'h8000_001F;
        CSR_MTVAL:    mtval_q    <= wval;
        default: ;
      endcase
    end
  end

`ifdef PEARL_COUNTERS_EN
  // Free-running counters; a write to either half holds the other half
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (csr_we && csr_addr_i == CSR_MCYCLE)
        mcycle_q[31:0] <= wval;
      else if (csr_we && csr_addr_i == CSR_MCYCLEH)
        mcycle_q[63:32] <= wval;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (csr_we && csr_addr_i == CSR_MINSTRET)
        minstret_q[31:0] <= wval;
      else if (csr_we && csr_addr_i == CSR_MINSTRETH)
        minstret_q[63:32] <= wval;
      else if (retire_i)
        minstret_q <= minstret_q + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trap_csr.sv
// Self-checking bench for trap_csr: directed scenarios plus randomized
// traffic against a behavioural model of the trap/CSR rules.
module tb_trap_csr;
  import csr_pkg::*;

  localparam int          NI       = 4;
  localparam logic [31:0] MIE_MASK = 32'h000F_0000;

  logic          clk = 1'b0;
  logic          arst;
  logic [NI-1:0] irq_i;
  logic          ex_valid_i, trap_i, mret_i, retire_i;
  logic [31:0]   ex_pc_i, trap_tval_i, csr_wdata_i;
  logic [3:0]    trap_cause_i;
  logic [11:0]   csr_addr_i;
  logic [1:0]    csr_op_i;
  logic [31:0]   csr_rdata_o, redirect_pc_o;
  logic          csr_illegal_o, redirect_o, irq_take_o;

  trap_csr #(.NUM_IRQ(NI), .MTVEC_RST(32'h0000_0100), .HARTID(32'd0)) dut (
    .clk(clk), .arst(arst), .irq_i(irq_i), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_tval_i(trap_tval_i),
    .mret_i(mret_i), .retire_i(retire_i), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .irq_take_o(irq_take_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // ---------------- behavioural model ----------------
  bit            m_mie, m_mpie;
  logic [31:0]   m_ie, m_tvec, m_scratch, m_epc, m_cause, m_tval;
  logic [63:0]   m_cyc, m_ret;
  logic [NI-1:0] hist[$];   // front = irq level from two cycles ago = visible mip

  logic [31:0]   e_rdata, e_pc;
  bit            e_ill, e_red, e_take;
  logic [4:0]    e_code;

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit known, output bit ro);
    known = 1; ro = 0; m_read = 32'd0;
    case (a)
      CSR_MSTATUS:  m_read = (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      CSR_MIE:      m_read = m_ie;
      CSR_MTVEC:    m_read = m_tvec;
      CSR_MSCRATCH: m_read = m_scratch;
      CSR_MEPC:     m_read = m_epc;
      CSR_MCAUSE:   m_read = m_cause;
      CSR_MTVAL:    m_read = m_tval;
      CSR_MIP:      begin m_read = 32'(hist[0]) << 16; ro = 1; end
      CSR_MHARTID:  begin m_read = 32'd0; ro = 1; end
`ifdef PEARL_COUNTERS_EN
      CSR_MCYCLE:    m_read = m_cyc[31:0];
      CSR_MCYCLEH:   m_read = m_cyc[63:32];
      CSR_MINSTRET:  m_read = m_ret[31:0];
      CSR_MINSTRETH: m_read = m_ret[63:32];
`endif
      default: known = 0;
    endcase
  endfunction

  task automatic eval();
    bit k, ro, found;
    logic [31:0] pend, base;
    e_rdata = m_read(csr_addr_i, k, ro);
    e_ill   = !k || (ro && csr_op_i != 2'b00);
    pend    = (32'(hist[0]) << 16) & m_ie;
    e_code  = 5'd0; found = 0;
    for (int b = 0; b < 32; b++)
      if (!found && pend[b]) begin e_code = 5'(b); found = 1; end
    e_take = !trap_i && !mret_i && m_mie && ex_valid_i && pend != 0;
    e_red  = trap_i || mret_i || e_take;
    base   = m_tvec & ~32'h3;
    if (trap_i)      e_pc = base;
    else if (mret_i) e_pc = m_epc;
    else             e_pc = m_tvec[0] ? base + 32'(e_code) * 4 : base;
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = 32'h100; m_scratch = 0;
    m_epc = 0; m_cause = 0; m_tval = 0; m_cyc = 0; m_ret = 0;
    hist.delete(); hist.push_back('0); hist.push_back('0);
  endtask

  task automatic model_step();
    logic [31:0] nv;
    logic [63:0] cyc0, ret0;
    bit we;
    eval();
    we = csr_op_i != 2'b00 && !e_ill && !e_red;
    case (csr_op_i)
      2'b01:   nv = csr_wdata_i;
      2'b10:   nv = e_rdata | csr_wdata_i;
      default: nv = e_rdata & ~csr_wdata_i;
    endcase
    cyc0 = m_cyc; ret0 = m_ret;
    m_cyc = m_cyc + 1;
    if (retire_i) m_ret = m_ret + 1;
    if (trap_i) begin
      m_epc = ex_pc_i; m_cause = {28'd0, trap_cause_i}; m_tval = trap_tval_i;
      m_mpie = m_mie; m_mie = 0;
    end else if (mret_i) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (e_take) begin
      m_epc = ex_pc_i; m_cause = 32'h8000_0000 | 32'(e_code); m_tval = 0;
      m_mpie = m_mie; m_mie = 0;
    end else if (we) begin
      case (csr_addr_i)
        CSR_MSTATUS:   begin m_mie = nv[3]; m_mpie = nv[7]; end
        CSR_MIE:       m_ie = nv & MIE_MASK;
        CSR_MTVEC:     m_tvec = nv & ~32'h2;
        CSR_MSCRATCH:  m_scratch = nv;
        CSR_MEPC:      m_epc = nv & ~32'h3;
        CSR_MCAUSE:    m_cause = nv & 32'h8000_001F;
        CSR_MTVAL:     m_tval = nv;
        CSR_MCYCLE:    m_cyc = {cyc0[63:32], nv};
        CSR_MCYCLEH:   m_cyc = {nv, cyc0[31:0]};
        CSR_MINSTRET:  m_ret = {ret0[63:32], nv};
        CSR_MINSTRETH: m_ret = {nv, ret0[31:0]};
        default: ;
      endcase
    end
    hist.push_back(irq_i);
    void'(hist.pop_front());
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic tick();
    @(posedge clk);
    if (arst) model_reset(); else model_step();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
    eval();
  endtask

  task automatic idle();
    irq_i = '0; ex_valid_i = 0; ex_pc_i = 0; trap_i = 0; trap_cause_i = 0;
    trap_tval_i = 0; mret_i = 0; retire_i = 0; csr_addr_i = 12'h000;
    csr_op_i = 2'b00; csr_wdata_i = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_addr_i = a; csr_op_i = op; csr_wdata_i = d;
    settle();
    tick();
    csr_op_i = 2'b00;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [11:0] addrs [9] = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                               CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MHARTID};
    logic [31:0] expv  [9] = '{32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      csr_addr_i = addrs[i];
      settle();
      vectors++;
      if (csr_rdata_o !== expv[i] || csr_illegal_o !== 1'b0 || redirect_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_csr addr %h got rdata %h ill %b red %b exp rdata %h ill 0 red 0",
                 addrs[i], csr_rdata_o, csr_illegal_o, redirect_o, expv[i]);
      end
      tick();
    end
  endtask

  task automatic test_irq_vector();
    csr_wr(CSR_MTVEC, 2'b01, 32'h101);
    csr_wr(CSR_MIE, 2'b01, 32'h0002_0000);
    csr_wr(CSR_MSTATUS, 2'b10, 32'h8);
    irq_i = 4'b0010; ex_valid_i = 1; ex_pc_i = 32'h40;
    for (int c = 0; c < 3; c++) begin
      settle();
      vectors++;
      if (irq_take_o !== (c == 2)) begin
        errors++;
        $display("FAIL irq_latency cycle %0d got take %b exp %b", c, irq_take_o, c == 2);
      end
      if (c == 2) begin
        vectors++;
        if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h144) begin
          errors++;
          $display("FAIL irq_vector got red %b pc %h exp red 1 pc 00000144", redirect_o, redirect_pc_o);
        end
      end
      tick();
    end
    ex_valid_i = 0;
    begin
      logic [11:0] a [3] = '{CSR_MCAUSE, CSR_MEPC, CSR_MSTATUS};
      logic [31:0] x [3] = '{32'h8000_0011, 32'h40, 32'h80};
      for (int i = 0; i < 3; i++) begin
        csr_addr_i = a[i];
        settle();
        vectors++;
        if (csr_rdata_o !== x[i]) begin
          errors++;
          $display("FAIL irq_state addr %h got %h exp %h", a[i], csr_rdata_o, x[i]);
        end
        tick();
      end
    end
  endtask

  task automatic test_mret();
    mret_i = 1;
    settle();
    vectors++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h40 || irq_take_o !== 1'b0) begin
      errors++;
      $display("FAIL mret_redirect got red %b pc %h take %b exp 1 00000040 0",
               redirect_o, redirect_pc_o, irq_take_o);
    end
    tick();
    mret_i = 0; csr_addr_i = CSR_MSTATUS;
    settle();
    vectors++;
    if (csr_rdata_o !== 32'h88) begin
      errors++;
      $display("FAIL mret_mstatus got %h exp 00000088", csr_rdata_o);
    end
    irq_i = '0;
    repeat (3) tick();
  endtask

  task automatic test_priority();
    csr_wr(CSR_MIE, 2'b01, 32'h000F_0000);
    irq_i = 4'b0110;
    tick(); tick();
    ex_valid_i = 1; trap_i = 1; trap_cause_i = EXC_ECALL_M; trap_tval_i = 32'hDEAD_BEEF;
    ex_pc_i = 32'h80;
    settle();
    vectors++;
    if (irq_take_o !== 1'b0 || redirect_o !== 1'b1 || redirect_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL trap_over_irq got take %b red %b pc %h exp 0 1 00000100",
               irq_take_o, redirect_o, redirect_pc_o);
    end
    tick();
    trap_i = 0; ex_valid_i = 0;
    begin
      logic [11:0] a [4] = '{CSR_MCAUSE, CSR_MTVAL, CSR_MEPC, CSR_MSTATUS};
      logic [31:0] x [4] = '{32'd11, 32'hDEAD_BEEF, 32'h80, 32'h80};
      for (int i = 0; i < 4; i++) begin
        csr_addr_i = a[i];
        settle();
        vectors++;
        if (csr_rdata_o !== x[i]) begin
          errors++;
          $display("FAIL trap_state addr %h got %h exp %h", a[i], csr_rdata_o, x[i]);
        end
        tick();
      end
    end
    csr_wr(CSR_MSTATUS, 2'b10, 32'h8);
    ex_valid_i = 1; ex_pc_i = 32'h90;
    settle();
    vectors++;
    if (irq_take_o !== 1'b1 || redirect_pc_o !== 32'h144) begin
      errors++;
      $display("FAIL irq_lowest got take %b pc %h exp 1 00000144", irq_take_o, redirect_pc_o);
    end
    tick();
    ex_valid_i = 0; csr_addr_i = CSR_MCAUSE;
    settle();
    vectors++;
    if (csr_rdata_o !== 32'h8000_0011) begin
      errors++;
      $display("FAIL irq_lowest_cause got %h exp 80000011", csr_rdata_o);
    end
    irq_i = '0;
    repeat (3) tick();
  endtask

  task automatic test_write_dropped();
    trap_i = 1; trap_cause_i = EXC_ILLEGAL_INSTR; ex_pc_i = 32'h200;
    csr_addr_i = CSR_MSTATUS; csr_op_i = 2'b10; csr_wdata_i = 32'h8;
    settle();
    tick();
    trap_i = 0; csr_op_i = 2'b00;
    settle();
    vectors++;
    if (csr_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL write_dropped mstatus got %h exp 00000000", csr_rdata_o);
    end
    tick();
  endtask

  task automatic test_warl();
    logic [11:0] a [6] = '{CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MIE, CSR_MSTATUS, CSR_MSCRATCH};
    logic [31:0] x [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h8000_001F, 32'h000F_0000,
                           32'h88, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      csr_wr(a[i], 2'b01, 32'hFFFF_FFFF);
      settle();
      vectors++;
      if (csr_rdata_o !== x[i]) begin
        errors++;
        $display("FAIL warl addr %h got %h exp %h", a[i], csr_rdata_o, x[i]);
      end
      tick();
    end
    csr_wr(CSR_MSTATUS, 2'b11, 32'h8);
    settle();
    vectors++;
    if (csr_rdata_o !== 32'h80) begin
      errors++;
      $display("FAIL clear_mstatus got %h exp 00000080", csr_rdata_o);
    end
    tick();
    csr_wr(CSR_MIE, 2'b11, 32'hFFFF_FFFF);
    csr_wr(CSR_MTVEC, 2'b01, 32'h100);
  endtask

  task automatic test_illegal();
    logic [11:0] a  [5] = '{CSR_MHARTID, 12'h7C0, CSR_MIP, 12'h123, CSR_MSCRATCH};
    logic [1:0]  op [5] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
    logic        il [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      csr_addr_i = a[i]; csr_op_i = op[i]; csr_wdata_i = 32'h1234_5678;
      settle();
      vectors++;
      if (csr_illegal_o !== il[i] || csr_rdata_o !== e_rdata) begin
        errors++;
        $display("FAIL illegal addr %h got ill %b rdata %h exp ill %b rdata %h",
                 a[i], csr_illegal_o, csr_rdata_o, il[i], e_rdata);
      end
      tick();
    end
    csr_op_i = 2'b00; csr_addr_i = CSR_MHARTID;
    settle();
    vectors++;
    if (csr_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL hartid_after_write got %h exp 00000000", csr_rdata_o);
    end
    tick();
  endtask

  task automatic test_counters();
`ifdef PEARL_COUNTERS_EN
    csr_wr(CSR_MCYCLE, 2'b01, 32'hFFFF_FFFF);
    csr_wr(CSR_MCYCLEH, 2'b01, 32'hFFFF_FFFF);
    begin
      logic [11:0] a [3] = '{CSR_MCYCLE, CSR_MCYCLE, CSR_MCYCLEH};
      logic [31:0] x [3] = '{32'hFFFF_FFFF, 32'h0, 32'h0};
      for (int i = 0; i < 3; i++) begin
        csr_addr_i = a[i];
        settle();
        vectors++;
        if (csr_rdata_o !== x[i] || csr_illegal_o !== 1'b0) begin
          errors++;
          $display("FAIL mcycle_wrap step %0d got %h ill %b exp %h ill 0", i, csr_rdata_o, csr_illegal_o, x[i]);
        end
        tick();
      end
    end
    csr_wr(CSR_MINSTRET, 2'b01, 32'hFFFF_FFFF);
    csr_wr(CSR_MINSTRETH, 2'b01, 32'hFFFF_FFFF);
    retire_i = 1; tick(); retire_i = 0;
    csr_addr_i = CSR_MINSTRET;
    settle();
    vectors++;
    if (csr_rdata_o !== 32'h0 || csr_rdata_o !== e_rdata) begin
      errors++;
      $display("FAIL minstret_wrap got %h exp 00000000", csr_rdata_o);
    end
    tick();
`else
    csr_addr_i = CSR_MCYCLE;
    settle();
    vectors++;
    if (csr_illegal_o !== 1'b1 || csr_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL no_counter got ill %b rdata %h exp ill 1 rdata 00000000", csr_illegal_o, csr_rdata_o);
    end
    tick();
    csr_addr_i = CSR_MINSTRETH; csr_op_i = 2'b01; csr_wdata_i = 32'h5;
    settle();
    vectors++;
    if (csr_illegal_o !== 1'b1) begin
      errors++;
      $display("FAIL no_counter_wr got ill %b exp 1", csr_illegal_o);
    end
    tick();
    csr_op_i = 2'b00;
`endif
  endtask

  task automatic test_random();
    logic [11:0] pool [14] = '{CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
                               CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MHARTID, 12'h123,
                               CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH};
    for (int n = 0; n < 400; n++) begin
      irq_i        = NI'($urandom);
      ex_valid_i   = $urandom_range(0, 3) != 0;
      ex_pc_i      = $urandom;
      trap_i       = $urandom_range(0, 15) == 0;
      trap_cause_i = 4'($urandom);
      trap_tval_i  = $urandom;
      mret_i       = $urandom_range(0, 15) == 0;
      retire_i     = 1'($urandom);
      csr_addr_i   = pool[$urandom_range(0, 13)];
      csr_op_i     = 2'($urandom);
      csr_wdata_i  = ($urandom_range(0, 1) == 1) ? 32'h0000_0088 | ($urandom & MIE_MASK) : $urandom;
      settle();
      vectors++;
      if (csr_rdata_o !== e_rdata || csr_illegal_o !== e_ill) begin
        errors++;
        $display("FAIL rnd_csr n %0d addr %h got %h/%b exp %h/%b", n, csr_addr_i,
                 csr_rdata_o, csr_illegal_o, e_rdata, e_ill);
      end
      vectors++;
      if (irq_take_o !== e_take || redirect_o !== e_red || (e_red && redirect_pc_o !== e_pc)) begin
        errors++;
        $display("FAIL rnd_redirect n %0d got take %b red %b pc %h exp %b %b %h", n,
                 irq_take_o, redirect_o, redirect_pc_o, e_take, e_red, e_pc);
      end
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_arst_midop();
    csr_wr(CSR_MIE, 2'b01, 32'h000F_0000);
    csr_wr(CSR_MSTATUS, 2'b01, 32'h8);
    irq_i = 4'b1111;
    tick(); tick();
    ex_valid_i = 1; ex_pc_i = 32'h300;
    arst = 1;
    model_reset();
    csr_addr_i = CSR_MTVEC;
    settle();
    vectors++;
    if (irq_take_o !== 1'b0 || redirect_o !== 1'b0 || csr_rdata_o !== 32'h100) begin
      errors++;
      $display("FAIL arst_async got take %b red %b mtvec %h exp 0 0 00000100",
               irq_take_o, redirect_o, csr_rdata_o);
    end
    tick(); tick();
    arst = 0;
    csr_addr_i = CSR_MIP;
    for (int c = 0; c < 4; c++) begin
      settle();
      vectors++;
      if (irq_take_o !== 1'b0 || csr_rdata_o !== e_rdata || (c < 2 && csr_rdata_o !== 32'h0)) begin
        errors++;
        $display("FAIL arst_release cycle %0d got take %b mip %h exp take 0 mip %h",
                 c, irq_take_o, csr_rdata_o, e_rdata);
      end
      tick();
    end
    ex_valid_i = 0;
    begin
      logic [11:0] a [6] = '{CSR_MSTATUS, CSR_MIE, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MSCRATCH};
      for (int i = 0; i < 6; i++) begin
        csr_addr_i = a[i];
        settle();
        vectors++;
        if (csr_rdata_o !== 32'h0) begin
          errors++;
          $display("FAIL arst_values addr %h got %h exp 00000000", a[i], csr_rdata_o);
        end
        tick();
      end
    end
  endtask

  initial begin
    idle();
    arst = 1;
    model_reset();
    repeat (3) tick();
    arst = 0;
    test_reset();
    test_irq_vector();
    test_mret();
    test_priority();
    test_write_dropped();
    test_warl();
    test_illegal();
    test_counters();
    test_random();
    test_arst_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
